wb_stage: RTL

//  Parametrised writeback stage for the 5-stage RV32I pipeline.

---
 rtl/wb_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Writeback stage for the 5-stage RV32I pipeline.
// Holds the MEM/WB pipeline register with stall and flush control.
// Sign- or zero-extends load data and picks the final register-file write value.
// Drives the register-file write port and the W-stage forwarding value.
// Optional feature: define WB_INSTRET_EN to add a retired-instruction counter.
// Without that macro, InstretW_o is tied to zero and the counter flops are not built.
module wb_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CNT_W   = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               StallW_i,
  input  logic               FlushW_i,
  input  logic               ValidM_i,
  input  logic               RegWriteM_i,
  input  logic [RADDR_W-1:0] RdM_i,
  input  logic [1:0]         ResultSrcM_i,
  input  logic [2:0]         LoadTypeM_i,
  input  logic [XLEN-1:0]    ALUResultM_i,
  input  logic [XLEN-1:0]    ReadDataM_i,
  input  logic [XLEN-1:0]    PCPlus4M_i,
  input  logic [XLEN-1:0]    ImmExtM_i,
  output logic               ValidW_o,
  output logic               RegWriteW_o,
  output logic [RADDR_W-1:0] RdW_o,
  output logic [XLEN-1:0]    ResultW_o,
  output logic [CNT_W-1:0]   InstretW_o
);

  localparam logic [1:0] SrcAlu  = 2'b00;
  localparam logic [1:0] SrcLoad = 2'b01;
  localparam logic [1:0] SrcPc4  = 2'b10;

  localparam logic [2:0] LdB  = 3'b000;
  localparam logic [2:0] LdH  = 3'b001;
  localparam logic [2:0] LdBu = 3'b100;
  localparam logic [2:0] LdHu = 3'b101;

  logic               valid_q;
  logic               regwrite_q;
  logic [RADDR_W-1:0] rd_q;
  logic [1:0]         src_q;
  logic [2:0]         ltype_q;
  logic [XLEN-1:0]    alu_q;
  logic [XLEN-1:0]    rdata_q;
  logic [XLEN-1:0]    pc4_q;
  logic [XLEN-1:0]    imm_q;

  logic [1:0]         byte_off;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [XLEN-1:0]    load_ext;
  logic [XLEN-1:0]    result;

  // MEM/WB register: reset > flush > stall > capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      src_q      <= '0;
      ltype_q    <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
    end else if (FlushW_i) begin
      // Data registers keep their old contents; only control is killed.
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
    end else if (!StallW_i) begin
      valid_q    <= ValidM_i;
      regwrite_q <= RegWriteM_i;
      rd_q       <= RdM_i;
      src_q      <= ResultSrcM_i;
      ltype_q    <= LoadTypeM_i;
      alu_q      <= ALUResultM_i;
      rdata_q    <= ReadDataM_i;
      pc4_q      <= PCPlus4M_i;
      imm_q      <= ImmExtM_i;
    end
  end

  // Load extension from the registered byte offset.
  always_comb begin
    byte_off = alu_q[1:0];
    ld_byte  = rdata_q[{byte_off, 3'b000} +: 8];
    // A misaligned halfword uses only off[1].
    ld_half  = byte_off[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_ext = rdata_q;
    case (ltype_q)
      LdB:     load_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      LdH:     load_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      LdBu:    load_ext = {{(XLEN-8){1'b0}}, ld_byte};
      LdHu:    load_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: load_ext = rdata_q;  // LW and undefined funct3 pass the word through
    endcase
  end

  // Final result mux, driven only from W registers.
  always_comb begin
    result = imm_q;
    case (src_q)
      SrcAlu:  result = alu_q;
      SrcLoad: result = load_ext;
      SrcPc4:  result = pc4_q;
      default: result = imm_q;
    endcase
  end

  assign ValidW_o    = valid_q;
  assign RegWriteW_o = regwrite_q & valid_q & (rd_q != '0);
  assign RdW_o       = rd_q;
  assign ResultW_o   = result;

`ifdef WB_INSTRET_EN
  logic [CNT_W-1:0] instret_q;

  // Count each instruction once as it leaves W; wraps silently.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instret_q <= '0;
    end else if (valid_q && !StallW_i) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign InstretW_o = instret_q;
`else
  assign InstretW_o = '0;
`endif

endmodule
